// File: rtl/router_src_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : router_src_ctrl
//  Purpose  : Ingress controller for the router source port. Accepts packets
//             (header, len payload bytes, parity byte) and steers every byte
//             into the per-channel FIFO selected by the header. It drives
//             backpressure, checks parity, flags bad packets and counts parity
//             errors plus dropped packets in a saturating counter.
//  Ports    : clk        - clock, rising edge
//             rstn       - asynchronous active-low reset
//             din        - packet byte from source
//             pkt_valid  - din valid; byte taken when pkt_valid && !busy
//             busy       - backpressure to source (combinational)
//             error      - registered; last packet bad (parity / bad dest)
//             fifo_full  - per-channel FIFO full
//             fifo_empty - per-channel FIFO empty
//             wr_en      - per-channel FIFO write strobe (one-hot or zero)
//             wr_data    - FIFO write data
//             pkt_done   - registered 1-cycle pulse on packet completion
//             err_cnt    - saturating count of parity errors plus drops
//  Revision : 1.0 - initial release
// ============================================================================
module router_src_ctrl #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              pkt_valid,
    output logic              busy,
    output logic              error,
    input  logic [N_CH-1:0]   fifo_full,
    input  logic [N_CH-1:0]   fifo_empty,
    output logic [N_CH-1:0]   wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              pkt_done,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int ADDR_W = $clog2(N_CH);
    localparam int LEN_W  = DATA_W - ADDR_W;

    // Channel count widened by one bit so that an out-of-range destination
    // compares correctly even when N_CH is not a power of two.
    localparam logic [ADDR_W:0] c_num_ch = (ADDR_W+1)'(N_CH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_EMPTY = 3'd1,
        S_PAYLOAD    = 3'd2,
        S_PARITY     = 3'd3,
        S_CHECK      = 3'd4,
        S_DROP       = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [DATA_W-1:0]   r_hdr;
    logic [LEN_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_parity;
    logic                r_mismatch;
    logic                r_error;
    logic                r_pkt_done;
    logic [CNT_W-1:0]    r_err_cnt;

    logic [ADDR_W-1:0]   w_hdr_dest;
    logic [LEN_W-1:0]    w_hdr_len;
    logic                w_hdr_dest_ok;
    logic                w_hdr_empty;
    logic [ADDR_W-1:0]   w_dest;
    logic                w_dest_full;
    logic                w_dest_empty;
    logic                w_busy;
    logic                w_accept;
    logic [N_CH-1:0]     w_wr_en;
    logic [DATA_W-1:0]   w_wr_data;

    // Address to one-hot channel select; out-of-range addresses decode to 0.
    function automatic logic [N_CH-1:0] dec_ch(input logic [ADDR_W-1:0] a);
        logic [N_CH-1:0] sel;
        sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (a == ADDR_W'(i)) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_hdr_dest    = din[ADDR_W-1:0];
    assign w_hdr_len     = din[DATA_W-1:ADDR_W];
    assign w_hdr_dest_ok = ({1'b0, w_hdr_dest} < c_num_ch);
    assign w_hdr_empty   = |(dec_ch(w_hdr_dest) & fifo_empty);

    // The held header always carries a valid destination once past IDLE.
    assign w_dest        = r_hdr[ADDR_W-1:0];
    assign w_dest_full   = |(dec_ch(w_dest) & fifo_full);
    assign w_dest_empty  = |(dec_ch(w_dest) & fifo_empty);

    // ------------------------------------------------------------------------
    // Backpressure
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_WAIT_EMPTY,
            S_CHECK:      w_busy = 1'b1;
            S_PAYLOAD,
            S_PARITY:     w_busy = w_dest_full;
            default:      w_busy = 1'b0;
        endcase
    end

    // Gating with rstn keeps a byte offered during reset from being written.
    assign w_accept = rstn & pkt_valid & ~w_busy;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and combinational write path
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = '0;
        w_wr_data    = din;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_hdr_dest_ok) begin
                        w_next_state = S_DROP;
                    end else if (!w_hdr_empty) begin
                        w_next_state = S_WAIT_EMPTY;
                    end else begin
                        w_wr_en      = dec_ch(w_hdr_dest);
                        w_next_state = (w_hdr_len != '0) ? S_PAYLOAD : S_PARITY;
                    end
                end
            end
            S_WAIT_EMPTY: begin
                // The held header goes out from the register, not from din.
                if (w_dest_empty) begin
                    w_wr_en      = dec_ch(w_dest);
                    w_wr_data    = r_hdr;
                    w_next_state = (r_cnt != '0) ? S_PAYLOAD : S_PARITY;
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    w_wr_en = dec_ch(w_dest);
                    if (r_cnt == LEN_W'(1)) begin
                        w_next_state = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_accept) begin
                    w_wr_en      = dec_ch(w_dest);
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next_state = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: header, length counter, parity, status and error counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hdr      <= '0;
            r_cnt      <= '0;
            r_parity   <= '0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
            r_pkt_done <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hdr    <= din;
                        r_cnt    <= w_hdr_len;
                        r_parity <= din;
                        // A new header clears the previous verdict unless
                        // the header itself is already bad.
                        r_error  <= ~w_hdr_dest_ok;
                        if (!w_hdr_dest_ok && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
                        r_parity <= r_parity ^ din;
                        r_cnt    <= r_cnt - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_accept) begin
                        r_mismatch <= (din != r_parity);
                    end
                end
                S_CHECK: begin
                    r_error    <= r_mismatch;
                    r_pkt_done <= 1'b1;
                    if (r_mismatch && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = w_busy;
    assign wr_en    = w_wr_en;
    assign wr_data  = w_wr_data;
    assign error    = r_error;
    assign pkt_done = r_pkt_done;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
